ir_frame_tx: RTL and testbench

Parametrised IR frame transmitter that replaces the fixed 38 kHz burst generator in the motion gate. It accepts a data word over a valid/ready handshake and emits a complete pulse-distance frame on `ir_sig`: leader mark, leader space, one mark/space pair per data bit, and a stop mark. Carrier frequency, duty cycle, unit timing, word width and per-symbol lengths are set by parameters. The output drives the IR LED driver directly.

---
 rtl/ir_frame_tx.sv | 162 ++++++++++++++++
 tb/tb_ir_frame_tx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ir_frame_tx.sv
// Pulse-distance IR frame transmitter: leader mark/space, one mark/space pair per data
// bit (LSB first), and a stop mark, with the carrier gated on during marks.
module ir_frame_tx #(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned CARRIER_HZ   = 38_000,
    parameter int unsigned DUTY_PCT     = 50,
    parameter int unsigned UNIT_US      = 562,
    parameter int unsigned DATA_BITS    = 32,
    parameter int unsigned LEAD_MARK_U  = 16,
    parameter int unsigned LEAD_SPACE_U = 8,
    parameter int unsigned ONE_SPACE_U  = 3,
    parameter int unsigned ZERO_SPACE_U = 1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    output logic                 busy_out,
    output logic                 done_out,
    output logic                 ir_sig
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned PERIOD   = CLK_HZ / CARRIER_HZ;
    localparam int unsigned HIGH     = PERIOD * DUTY_PCT / 100;
    localparam int unsigned UNIT_CYC = CLK_HZ / 1_000_000 * UNIT_US;
    localparam int unsigned MAX_N    = max2(max2(max2(LEAD_MARK_U, LEAD_SPACE_U),
                                                  max2(ONE_SPACE_U, ZERO_SPACE_U)), 1);
    localparam int unsigned CYC_W    = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
    localparam int unsigned UNIT_W   = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam int unsigned BIT_W    = $clog2(DATA_BITS) + 1;
    localparam int unsigned PH_W     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    // Reject parameter sets that cannot produce a valid carrier or unit timing.
    if (PERIOD < 2) begin : g_chk_period
        $error("ir_frame_tx: carrier period must be at least 2 clock cycles");
    end
    if (HIGH < 1 || HIGH >= PERIOD) begin : g_chk_high
        $error("ir_frame_tx: carrier high time must satisfy 1 <= HIGH < PERIOD");
    end
    if (UNIT_CYC < 1) begin : g_chk_unit
        $error("ir_frame_tx: timing unit must be at least one clock cycle");
    end
    if (LEAD_MARK_U < 1 || LEAD_SPACE_U < 1 || ONE_SPACE_U < 1 || ZERO_SPACE_U < 1) begin : g_chk_len
        $error("ir_frame_tx: every symbol must last at least one unit");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_MARK,
        S_LEAD_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE,
        S_STOP_MARK
    } state_t;

    state_t               state, state_n;
    logic [CYC_W-1:0]     cyc, cyc_n;
    logic [UNIT_W-1:0]    unit, unit_n;
    logic [BIT_W-1:0]     bit_idx, bit_idx_n;
    logic [PH_W-1:0]      phase, phase_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 ready_n, busy_n, done_n, ir_n;
    logic                 is_mark, cyc_last, sym_end;
    int unsigned          sym_units;

    // State, counters and registered outputs.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= S_IDLE;
            cyc       <= '0;
            unit      <= '0;
            bit_idx   <= '0;
            phase     <= '0;
            shreg     <= '0;
            ready_out <= 1'b1;
            busy_out  <= 1'b0;
            done_out  <= 1'b0;
            ir_sig    <= 1'b0;
        end else begin
            state     <= state_n;
            cyc       <= cyc_n;
            unit      <= unit_n;
            bit_idx   <= bit_idx_n;
            phase     <= phase_n;
            shreg     <= shreg_n;
            ready_out <= ready_n;
            busy_out  <= busy_n;
            done_out  <= done_n;
            ir_sig    <= ir_n;
        end
    end

    // Next-state, counter and output logic.
    always_comb begin
        state_n   = state;
        cyc_n     = cyc;
        unit_n    = unit;
        bit_idx_n = bit_idx;
        phase_n   = '0;
        shreg_n   = shreg;
        done_n    = 1'b0;

        is_mark = (state == S_LEAD_MARK) || (state == S_BIT_MARK) || (state == S_STOP_MARK);

        case (state)
            S_LEAD_MARK:  sym_units = LEAD_MARK_U;
            S_LEAD_SPACE: sym_units = LEAD_SPACE_U;
            S_BIT_SPACE:  sym_units = shreg[0] ? ONE_SPACE_U : ZERO_SPACE_U;
            default:      sym_units = 1;
        endcase

        cyc_last = (cyc == CYC_W'(UNIT_CYC - 1));
        sym_end  = cyc_last && (unit == UNIT_W'(sym_units - 1));

        if (state == S_IDLE) begin
            cyc_n  = '0;
            unit_n = '0;
            if (valid_in && ready_out) begin
                shreg_n   = data_in;
                bit_idx_n = '0;
                state_n   = S_LEAD_MARK;
            end
        end else if (sym_end) begin
            cyc_n  = '0;
            unit_n = '0;
            case (state)
                S_LEAD_MARK:  state_n = S_LEAD_SPACE;
                S_LEAD_SPACE: state_n = S_BIT_MARK;
                S_BIT_MARK:   state_n = S_BIT_SPACE;
                S_BIT_SPACE: begin
                    shreg_n   = shreg >> 1;
                    bit_idx_n = bit_idx + BIT_W'(1);
                    state_n   = (bit_idx == BIT_W'(DATA_BITS - 1)) ? S_STOP_MARK : S_BIT_MARK;
                end
                default: begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end
            endcase
        end else if (cyc_last) begin
            cyc_n  = '0;
            unit_n = unit + UNIT_W'(1);
        end else begin
            cyc_n = cyc + CYC_W'(1);
        end

        // Marks never follow marks, so staying in a mark state means the carrier keeps running.
        if (is_mark && (state_n == state)) begin
            phase_n = (phase == PH_W'(PERIOD - 1)) ? '0 : phase + PH_W'(1);
        end

        ir_n    = is_mark && (phase < PH_W'(HIGH));
        busy_n  = (state_n != S_IDLE);
        ready_n = (state_n == S_IDLE);
    end

endmodule

// File: tb/tb_ir_frame_tx.sv
// Directed bench for ir_frame_tx: frame timing, carrier shape, handshake and reset.
module tb_ir_frame_tx;

    localparam int UC  = 20;   // unit cycles with 1 MHz clock and 20 us units
    localparam int PER = 10;   // carrier period with 100 kHz carrier

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic [3:0] data_in;
    logic       valid_in;
    logic       ready_out, busy_out, done_out, ir_sig;

    logic [0:0] data5;
    logic       valid5;
    logic       ready5, busy5, done5, ir5;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk_in = ~clk_in;

    ir_frame_tx #(
        .CLK_HZ(1_000_000), .CARRIER_HZ(100_000), .DUTY_PCT(50), .UNIT_US(20), .DATA_BITS(4)
    ) u_dut (
        .clk_in(clk_in), .rst_in(rst_in), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out), .busy_out(busy_out), .done_out(done_out), .ir_sig(ir_sig)
    );

    ir_frame_tx #(
        .CLK_HZ(1_000_000), .CARRIER_HZ(100_000), .DUTY_PCT(30), .UNIT_US(20), .DATA_BITS(1)
    ) u_dut5 (
        .clk_in(clk_in), .rst_in(rst_in), .data_in(data5), .valid_in(valid5),
        .ready_out(ready5), .busy_out(busy5), .done_out(done5), .ir_sig(ir5)
    );

    typedef struct {
        logic [3:0] data;
        int         exp_len;   // busy cycles == frame length
        int         exp_high;  // ir_sig high cycles over the whole frame
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Handshake: waits (bounded) for idle, then presents the word for one edge.
    task automatic send(input logic [3:0] d);
        int i;
        @(negedge clk_in);
        for (i = 0; i < 20 && !ready_out; i++) @(negedge clk_in);
        check("send_ready", int'(ready_out), 1);
        data_in  = d;
        valid_in = 1'b1;
        @(posedge clk_in);
    endtask

    // Called right after the accepting edge; follows the frame to its done cycle.
    task automatic run_frame(input logic [3:0] d, input bit hold, input logic [3:0] next_d,
                             input string tag, output int busy_cnt, output int high_cnt);
        int  slen[11];
        bit  smark[11];
        int  bad[11];
        int  pos_sym[900];
        bit  pos_exp[900];
        int  p, total, done_cnt, done_k, rdy_bad, pos;
        bit  exp_ir;
        slen[0] = 16 * UC; smark[0] = 1'b1;
        slen[1] = 8 * UC;  smark[1] = 1'b0;
        for (int b = 0; b < 4; b++) begin
            slen[2 + 2*b] = UC;                       smark[2 + 2*b] = 1'b1;
            slen[3 + 2*b] = (d[b] ? 3 : 1) * UC;      smark[3 + 2*b] = 1'b0;
        end
        slen[10] = UC; smark[10] = 1'b1;
        p = 0;
        for (int s = 0; s < 11; s++) begin
            bad[s] = 0;
            for (int o = 0; o < slen[s]; o++) begin
                pos_sym[p] = s;
                pos_exp[p] = smark[s] && ((o % PER) < 5);
                p++;
            end
        end
        total = p;
        busy_cnt = 0; high_cnt = 0; done_cnt = 0; done_k = 0; rdy_bad = 0;
        for (int k = 1; k <= total + 1; k++) begin
            @(negedge clk_in);
            if (k == 1) begin
                if (hold) data_in = next_d;
                else      valid_in = 1'b0;
            end
            if (busy_out) busy_cnt++;
            if (ready_out == busy_out) rdy_bad++;
            if (done_out) begin
                done_cnt++;
                done_k = k;
            end
            if (k >= 2) begin
                pos    = k - 2;
                exp_ir = pos_exp[pos];
                if (ir_sig != exp_ir) bad[pos_sym[pos]]++;
                if (ir_sig) high_cnt++;
            end
        end
        for (int s = 0; s < 11; s++)
            check($sformatf("%s_sym%0d_wave_errs", tag, s), bad[s], 0);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_done_cycle"}, done_k, total + 1);
        check({tag, "_ready_vs_busy_errs"}, rdy_bad, 0);
        check({tag, "_ready_at_done"}, int'(ready_out), 1);
    endtask

    initial begin
        vec_t vecs[5];
        int   bc, hc, lead_bad, pos;
        int   b5, h5, d5c, d5k;

        vecs[0] = '{4'b0101, 740, 210};
        vecs[1] = '{4'b0000, 660, 210};
        vecs[2] = '{4'b1111, 820, 210};
        vecs[3] = '{4'b1000, 700, 210};
        vecs[4] = '{4'b0001, 700, 210};

        // Reset with idle inputs.
        rst_in = 1'b0; valid_in = 1'b0; data_in = 4'h0; valid5 = 1'b0; data5 = 1'b0;
        repeat (3) @(negedge clk_in);
        check("rst_ready", int'(ready_out), 1);
        check("rst_busy",  int'(busy_out), 0);
        check("rst_ir",    int'(ir_sig), 0);
        check("rst_done",  int'(done_out), 0);
        check("rst_ready5", int'(ready5), 1);
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);
        check("idle_busy", int'(busy_out), 0);

        // Table of single frames.
        for (int i = 0; i < 5; i++) begin
            send(vecs[i].data);
            run_frame(vecs[i].data, 1'b0, 4'h0, $sformatf("vec%0d", i), bc, hc);
            check($sformatf("vec%0d_frame_len", i), bc, vecs[i].exp_len);
            check($sformatf("vec%0d_high_cycles", i), hc, vecs[i].exp_high);
            repeat (3) @(negedge clk_in);
        end

        // valid held through a frame: next word taken only on the done cycle.
        send(4'b0110);
        run_frame(4'b0110, 1'b1, 4'b1001, "holdA", bc, hc);
        check("holdA_frame_len", bc, 740);
        run_frame(4'b1001, 1'b0, 4'h0, "holdB", bc, hc);
        check("holdB_frame_len", bc, 740);
        check("holdB_high_cycles", hc, 210);

        // Asynchronous reset in the middle of the first bit mark.
        repeat (3) @(negedge clk_in);
        send(4'b0101);
        for (int k = 1; k <= 485; k++) begin
            @(negedge clk_in);
            if (k == 1) valid_in = 1'b0;
        end
        check("pre_rst_ir", int'(ir_sig), 1);
        check("pre_rst_busy", int'(busy_out), 1);
        rst_in = 1'b0;
        #1;
        check("async_rst_ir", int'(ir_sig), 0);
        check("async_rst_ready", int'(ready_out), 1);
        check("async_rst_busy", int'(busy_out), 0);
        check("async_rst_done", int'(done_out), 0);
        @(negedge clk_in);
        rst_in = 1'b1;
        send(4'b0011);
        run_frame(4'b0011, 1'b0, 4'h0, "postrst", bc, hc);
        check("postrst_frame_len", bc, 740);

        // 30% duty, one data bit set: (16+8+1+3+1)*20 = 580 cycles, marks 3-high/7-low.
        @(negedge clk_in);
        data5  = 1'b1;
        valid5 = 1'b1;
        @(posedge clk_in);
        b5 = 0; h5 = 0; d5c = 0; d5k = 0; lead_bad = 0;
        for (int k = 1; k <= 581; k++) begin
            @(negedge clk_in);
            if (k == 1) valid5 = 1'b0;
            if (busy5) b5++;
            if (done5) begin
                d5c++;
                d5k = k;
            end
            if (k >= 2) begin
                pos = k - 2;
                if (ir5) h5++;
                if (pos < 320 && (ir5 != ((pos % PER) < 3))) lead_bad++;
            end
        end
        check("duty30_frame_len", b5, 580);
        check("duty30_high_cycles", h5, 108);
        check("duty30_done_count", d5c, 1);
        check("duty30_done_cycle", d5k, 581);
        check("duty30_lead_wave_errs", lead_bad, 0);
        check("duty30_ready_at_done", int'(ready5), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
